// File: rtl/lmcnt_p.sv
// Local-memory operand streamer: reads A/B vectors from selectable local memories,
// streams them to the NPU, and writes the returned C stream back to memory.
module lmcnt_p #(
  parameter int DW   = 8,
  parameter int AW   = 10,
  parameter int NMEM = 4,
  parameter int SW   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SOFT_RESET,
  input  logic                 START,
  output logic                 FINISH,
  output logic                 ERR,
  output logic                 BUSY,
  input  logic [SW-1:0]        MSEL_A,
  input  logic [SW-1:0]        MSEL_B,
  input  logic [SW-1:0]        MSEL_C,
  input  logic [AW-1:0]        POS_A,
  input  logic [AW-1:0]        POS_B,
  input  logic [AW-1:0]        POS_C,
  input  logic [AW-1:0]        SIZE,
  input  logic                 BCAST_B,
  output logic [NMEM*AW-1:0]   M_RADR,
  input  logic [NMEM*DW-1:0]   M_RDATA,
  output logic [NMEM-1:0]      M_WR,
  output logic [NMEM*AW-1:0]   M_WADR,
  output logic [NMEM*DW-1:0]   M_WDATA,
  output logic                 NPU_EN,
  output logic [DW-1:0]        A_RDATA,
  output logic [DW-1:0]        B_RDATA,
  input  logic                 LM_EN,
  input  logic [DW-1:0]        C_WDATA
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wr_cnt;
  logic          err_q;
  logic [SW-1:0] msel_a_q, msel_b_q, msel_c_q;
  logic [AW-1:0] pos_a_q, pos_b_q, pos_c_q, size_q;
  logic          bcast_q;
  logic          cfg_bad;
  logic          start_ok;
  logic          wr_fire;
  logic          vld_p1, vld_p2;
  logic [DW-1:0] a_rd_p1, b_rd_p1;
  logic [DW-1:0] a_data_p2, b_data_p2;

  // Memory 0 is read-only and A/B must come from distinct ports.
  always_comb begin
    cfg_bad = (MSEL_C == '0) || (MSEL_A == MSEL_B) ||
              (int'(MSEL_A) >= NMEM) || (int'(MSEL_B) >= NMEM) || (int'(MSEL_C) >= NMEM);
  end

  assign start_ok = (state == S_IDLE) && START;
  assign wr_fire  = LM_EN && ((state == S_RUN) || (state == S_DRAIN)) && (wr_cnt < size_q);

  always_ff @(posedge CLK) begin
    if (start_ok) begin
      msel_a_q <= MSEL_A;
      msel_b_q <= MSEL_B;
      msel_c_q <= MSEL_C;
      pos_a_q  <= POS_A;
      pos_b_q  <= POS_B;
      pos_c_q  <= POS_C;
      size_q   <= SIZE;
      bcast_q  <= BCAST_B;
    end
  end

  // Stage p0: address issue in RUN; p1: memory data returns; p2: registered to NPU.
  always_comb begin
    M_RADR = '0;
    if (state == S_RUN) begin
      M_RADR[int'(msel_a_q)*AW +: AW] = pos_a_q + rd_cnt;
      M_RADR[int'(msel_b_q)*AW +: AW] = bcast_q ? pos_b_q : pos_b_q + rd_cnt;
    end
  end

  assign a_rd_p1 = M_RDATA[int'(msel_a_q)*DW +: DW];
  assign b_rd_p1 = M_RDATA[int'(msel_b_q)*DW +: DW];

  always_comb begin
    M_WR    = '0;
    M_WADR  = '0;
    M_WDATA = '0;
    if (wr_fire) begin
      M_WR                            = NMEM'(1) << msel_c_q;
      M_WADR[int'(msel_c_q)*AW +: AW]  = pos_c_q + wr_cnt;
      M_WDATA[int'(msel_c_q)*DW +: DW] = C_WDATA;
    end
    M_WR[0]         = 1'b0;
    M_WADR[AW-1:0]  = '0;
    M_WDATA[DW-1:0] = '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      err_q     <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      a_data_p2 <= '0;
      b_data_p2 <= '0;
    end else if (SOFT_RESET) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      err_q     <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      a_data_p2 <= '0;
      b_data_p2 <= '0;
    end else begin
      vld_p1 <= (state == S_RUN);
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        a_data_p2 <= a_rd_p1;
        b_data_p2 <= b_rd_p1;
      end
      if (wr_fire) wr_cnt <= wr_cnt + AW'(1);
      case (state)
        S_IDLE: begin
          if (START) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            err_q  <= cfg_bad;
            state  <= (cfg_bad || (SIZE == '0)) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          rd_cnt <= rd_cnt + AW'(1);
          if (rd_cnt == size_q - AW'(1)) state <= S_DRAIN;
        end
        // Wait for the read pipeline to empty as well, so no NPU beat outlives the job.
        S_DRAIN: if ((wr_cnt == size_q) && !vld_p1 && !vld_p2) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign FINISH  = (state == S_DONE);
  assign BUSY    = (state != S_IDLE);
  assign ERR     = err_q;
  assign NPU_EN  = vld_p2;
  assign A_RDATA = a_data_p2;
  assign B_RDATA = b_data_p2;

endmodule

// File: tb/tb_lmcnt_p.sv
// Scoreboard bench for lmcnt_p: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_lmcnt_p;
  localparam int DW = 8, AW = 10, NMEM = 4, SW = 2;

  logic CLK = 1'b0, RESET, SOFT_RESET, START, BCAST_B, LM_EN;
  logic FINISH, ERR, BUSY, NPU_EN;
  logic [SW-1:0] MSEL_A, MSEL_B, MSEL_C;
  logic [AW-1:0] POS_A, POS_B, POS_C, SIZE;
  logic [NMEM*AW-1:0] M_RADR, M_WADR;
  logic [NMEM*DW-1:0] M_RDATA, M_WDATA;
  logic [NMEM-1:0] M_WR;
  logic [DW-1:0] A_RDATA, B_RDATA, C_WDATA;

  lmcnt_p #(.DW(DW), .AW(AW), .NMEM(NMEM), .SW(SW)) dut (
    .CLK(CLK), .RESET(RESET), .SOFT_RESET(SOFT_RESET), .START(START),
    .FINISH(FINISH), .ERR(ERR), .BUSY(BUSY),
    .MSEL_A(MSEL_A), .MSEL_B(MSEL_B), .MSEL_C(MSEL_C),
    .POS_A(POS_A), .POS_B(POS_B), .POS_C(POS_C), .SIZE(SIZE), .BCAST_B(BCAST_B),
    .M_RADR(M_RADR), .M_RDATA(M_RDATA), .M_WR(M_WR), .M_WADR(M_WADR), .M_WDATA(M_WDATA),
    .NPU_EN(NPU_EN), .A_RDATA(A_RDATA), .B_RDATA(B_RDATA), .LM_EN(LM_EN), .C_WDATA(C_WDATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Preloaded memory content: distinct values per address within any 256-word window.
  function automatic logic [7:0] memval(input int sel, input int a);
    return 8'(a * 7 + sel * 61);
  endfunction

  always @(posedge CLK)
    for (int i = 0; i < NMEM; i++) M_RDATA[i*DW +: DW] <= memval(i, int'(M_RADR[i*AW +: AW]));

  typedef struct { int cyc; int sa; int adr_a; int sb; int adr_b; } radr_t;
  typedef struct { int cyc; int a; int b; } npu_t;
  typedef struct { int sel; int adr; int data; } wr_t;
  typedef struct { int cyc; int err; } fin_t;
  radr_t radr_q[$];
  npu_t  npu_q[$];
  wr_t   wr_q[$];
  fin_t  fin_q[$];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d: output active with nothing expected", name, cyc);
  endtask

  radr_t mr;
  npu_t  mn;
  wr_t   mw;
  fin_t  mf;
  always @(negedge CLK) begin
    if (radr_q.size() != 0 && radr_q[0].cyc == cyc) begin
      mr = radr_q.pop_front();
      chk("radr_a", int'(M_RADR[mr.sa*AW +: AW]), mr.adr_a);
      chk("radr_b", int'(M_RADR[mr.sb*AW +: AW]), mr.adr_b);
      chk("radr_idle0", int'(M_RADR[AW-1:0]), 0);
    end
    if (NPU_EN) begin
      if (npu_q.size() == 0) unexpected("npu_en");
      else begin
        mn = npu_q.pop_front();
        chk("npu_cyc", cyc, mn.cyc);
        chk("a_rdata", int'(A_RDATA), mn.a);
        chk("b_rdata", int'(B_RDATA), mn.b);
      end
    end
    if (|M_WR) begin
      if (wr_q.size() == 0) unexpected("m_wr");
      else begin
        mw = wr_q.pop_front();
        chk("wr_sel", int'(M_WR), 1 << mw.sel);
        chk("wr_adr", int'(M_WADR[mw.sel*AW +: AW]), mw.adr);
        chk("wr_data", int'(M_WDATA[mw.sel*DW +: DW]), mw.data);
      end
    end
    if (FINISH) begin
      if (fin_q.size() == 0) unexpected("finish");
      else begin
        mf = fin_q.pop_front();
        if (mf.cyc >= 0) chk("finish_cyc", cyc, mf.cyc);
        chk("finish_err", int'(ERR), mf.err);
      end
    end
  end

  task automatic start_job(input int sa, input int pa, input int sb, input int pb,
                           input int sc, input int pc, input int sz, input int bc, input int bad);
    int n;
    @(posedge CLK); #1;
    MSEL_A = SW'(sa); MSEL_B = SW'(sb); MSEL_C = SW'(sc);
    POS_A = AW'(pa); POS_B = AW'(pb); POS_C = AW'(pc); SIZE = AW'(sz); BCAST_B = bc[0];
    START = 1'b1;
    n = cyc;
    if (bad != 0) fin_q.push_back('{n + 1, 1});
    else if (sz == 0) fin_q.push_back('{n + 1, 0});
    else begin
      for (int k = 0; k < sz; k++) begin
        radr_q.push_back('{n + 1 + k, sa, (pa + k) % 1024, sb, (bc != 0) ? pb : (pb + k) % 1024});
        npu_q.push_back('{n + 3 + k, int'(memval(sa, (pa + k) % 1024)),
                          int'(memval(sb, (bc != 0) ? pb : (pb + k) % 1024))});
      end
      fin_q.push_back('{-1, 0});
    end
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic feed_writes(input int sc, input int pc, input int sz, input int nwr);
    for (int j = 0; j < nwr; j++) begin
      LM_EN = 1'b1;
      C_WDATA = 8'(8'hA0 + j + sc * 16);
      if (j < sz) wr_q.push_back('{sc, (pc + j) % 1024, int'(C_WDATA)});
      @(posedge CLK); #1;
    end
    LM_EN = 1'b0;
  endtask

  task automatic wait_finish(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge CLK);
      if (FINISH) break;
    end
    if (k == limit) chk("finish_timeout", 0, 1);
    @(posedge CLK); #1;
    chk("busy_after", int'(BUSY), 0);
  endtask

  task automatic run_job(input int sa, input int pa, input int sb, input int pb, input int sc,
                         input int pc, input int sz, input int bc, input int nwr, input int restart);
    start_job(sa, pa, sb, pb, sc, pc, sz, bc, 0);
    chk("busy_run", int'(BUSY), 1);
    if (restart != 0) begin
      START = 1'b1; MSEL_A = 2'd3; MSEL_B = 2'd0; SIZE = AW'(2); POS_A = AW'(500);
      @(posedge CLK); #1;
      START = 1'b0;
    end
    repeat (sz + 3) @(posedge CLK);
    #1;
    feed_writes(sc, pc, sz, nwr);
    wait_finish(40);
  endtask

  task automatic flush_all();
    radr_q.delete(); npu_q.delete(); wr_q.delete(); fin_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_finish"}, int'(FINISH), 0);
    chk({tag, "_err"}, int'(ERR), 0);
    chk({tag, "_npu_en"}, int'(NPU_EN), 0);
    chk({tag, "_a_rdata"}, int'(A_RDATA), 0);
    chk({tag, "_b_rdata"}, int'(B_RDATA), 0);
    chk({tag, "_m_wr"}, int'(M_WR), 0);
    chk({tag, "_m_radr"}, int'(M_RADR), 0);
    chk({tag, "_m_wadr"}, int'(M_WADR), 0);
  endtask

  initial begin
    RESET = 1'b1; SOFT_RESET = 1'b0; START = 1'b0; BCAST_B = 1'b0; LM_EN = 1'b0;
    MSEL_A = '0; MSEL_B = '0; MSEL_C = '0; POS_A = '0; POS_B = '0; POS_C = '0; SIZE = '0;
    C_WDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle("reset");
    RESET = 1'b0;

    // Basic job, address wrap on reads and writes, broadcast B.
    run_job(1, 0, 2, 8, 3, 16, 4, 0, 4, 0);
    run_job(2, 1022, 1, 100, 3, 1022, 4, 0, 4, 0);
    run_job(3, 40, 1, 5, 2, 200, 3, 1, 3, 0);

    // Illegal configurations: C in read-only memory, then A and B on the same memory.
    start_job(1, 0, 2, 8, 0, 16, 4, 0, 1);
    LM_EN = 1'b1; C_WDATA = 8'h55;
    wait_finish(10);
    LM_EN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("err_sticky", int'(ERR), 1);
    start_job(1, 0, 1, 8, 3, 16, 4, 1, 1);
    wait_finish(10);

    // Empty job clears ERR and finishes at once; then a restart attempt in RUN and a surplus LM_EN.
    start_job(1, 0, 2, 8, 3, 16, 0, 0, 0);
    chk("err_clear", int'(ERR), 0);
    wait_finish(10);
    run_job(1, 300, 2, 600, 3, 700, 4, 0, 5, 1);

    // Asynchronous reset in the middle of streaming.
    start_job(1, 0, 2, 8, 3, 16, 8, 0, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    RESET = 1'b1;
    flush_all();
    #1;
    chk_idle("async_rst");
    @(posedge CLK); #1;
    RESET = 1'b0;
    run_job(1, 0, 2, 8, 3, 16, 4, 0, 4, 0);

    // Synchronous soft reset shortly after start.
    start_job(2, 10, 3, 20, 1, 30, 6, 0, 0);
    @(posedge CLK); #1;
    SOFT_RESET = 1'b1;
    @(posedge CLK); #1;
    SOFT_RESET = 1'b0;
    flush_all();
    chk_idle("soft_rst");
    run_job(2, 10, 3, 20, 1, 30, 6, 0, 6, 0);

    repeat (5) @(posedge CLK);
    #1;
    chk("radr_left", radr_q.size(), 0);
    chk("npu_left", npu_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("fin_left", fin_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule

// File: doc/lmcnt_p.md
LMCNT_P -- requirements
Module: lmcnt_p

Interface
REQ-001 SHALL have parameter DW, default 8, local-memory data width in bits.
REQ-002 SHALL have parameter AW, default 10, local-memory address width in bits.
REQ-003 SHALL have parameter NMEM, default 4, number of local memories; memory 0 is read-only.
REQ-004 SHALL have parameter SW, default 2, select width; NMEM <= 2**SW.
REQ-005 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port SOFT_RESET  in  1  synchronous active-high clear, same effect as RESET.
REQ-008 SHALL have port START  in  1  single-cycle job start pulse.
REQ-009 SHALL have port FINISH  out  1  one-cycle job-complete pulse.
REQ-010 SHALL have port ERR  out  1  sticky illegal-configuration flag.
REQ-011 SHALL have port BUSY  out  1  high while not IDLE.
REQ-012 SHALL have ports MSEL_A, MSEL_B, MSEL_C  in  SW each  memory selects for operand A, operand B and result C.
REQ-013 SHALL have ports POS_A, POS_B, POS_C  in  AW each  base addresses.
REQ-014 SHALL have port SIZE  in  AW  element count; 0 is legal.
REQ-015 SHALL have port BCAST_B  in  1  1 = hold B address at POS_B for all elements.
REQ-016 SHALL have port M_RADR  out  NMEM*AW  per-memory read address, slice i = memory i.
REQ-017 SHALL have port M_RDATA  in  NMEM*DW  per-memory read data, one-cycle synchronous read.
REQ-018 SHALL have ports M_WR  out  NMEM, M_WADR  out  NMEM*AW, M_WDATA  out  NMEM*DW  per-memory write; bit/slice 0 tied 0.
REQ-019 SHALL have ports NPU_EN  out  1, A_RDATA  out  DW, B_RDATA  out  DW  operand stream to NPU.
REQ-020 SHALL have ports LM_EN  in  1, C_WDATA  in  DW  result stream from NPU.

Function
REQ-021 SHALL implement states IDLE, RUN, DRAIN, DONE; START is sampled only in IDLE and ignored otherwise.
REQ-022 SHALL, on START in IDLE, latch all config inputs, clear rd_cnt/wr_cnt, and enter RUN; SIZE=0 enters DONE directly.
REQ-023 SHALL, at START, set ERR and enter DONE without any access if MSEL_C = 0, or if any select >= NMEM.
REQ-024 SHALL, in RUN, drive M_RADR[MSEL_A] = POS_A+rd_cnt and M_RADR[MSEL_B] = POS_B+rd_cnt (POS_B if BCAST_B), incrementing rd_cnt each cycle; all sums are modulo 2**AW (wrap).
REQ-025 SHALL, when MSEL_A = MSEL_B without BCAST_B, set ERR at START and enter DONE; with BCAST_B and equal selects, the same condition applies.
REQ-026 SHALL leave RUN for DRAIN after SIZE addresses are issued.
REQ-027 SHALL register the selected M_RDATA into A_RDATA/B_RDATA with NPU_EN high; latency 2 cycles from address issue, so NPU_EN is high for exactly SIZE consecutive cycles.
REQ-028 SHALL, on each LM_EN while BUSY and wr_cnt < SIZE, pulse M_WR[MSEL_C] with M_WADR = POS_C+wr_cnt (wrapping) and M_WDATA = C_WDATA in the same cycle, then increment wr_cnt.
REQ-029 SHALL ignore LM_EN in IDLE, in DONE, or when wr_cnt = SIZE.
REQ-030 SHALL accept LM_EN during RUN, since writes may overlap reads; MSEL_C may equal MSEL_A or MSEL_B.
REQ-031 SHALL go from DRAIN to DONE when wr_cnt = SIZE, and from DONE to IDLE after one cycle with FINISH high in DONE.
REQ-032 SHALL drive inactive M_RADR and M_WADR slices to 0.

Reset
REQ-033 SHALL, on RESET (async) or SOFT_RESET (sync), go to IDLE with counters 0 and FINISH, ERR, BUSY, NPU_EN, M_WR = 0 and A_RDATA, B_RDATA = 0, including mid-job.
REQ-034 SHALL clear ERR only by reset or by the next accepted START.

Verification
REQ-035 Bench SHALL check: SIZE=4, A sel1 POS 0, B sel2 POS 8, C sel3 POS 16, memories preloaded -> NPU_EN high 4 cycles, starting 3 cycles after START; after 4 LM_EN, M_WADR = 16..19, then FINISH.
REQ-036 Bench SHALL check: POS_A = 1022, SIZE = 4 (AW = 10) -> read addresses 1022, 1023, 0, 1.
REQ-037 Bench SHALL check: BCAST_B = 1, POS_B = 5, SIZE = 3 -> B address 5 on all 3 cycles, with B_RDATA constant.
REQ-038 Bench SHALL check: MSEL_C = 0 -> ERR = 1, FINISH pulse, and no M_WR or NPU_EN.
REQ-039 Bench SHALL check: SIZE = 0 -> FINISH 1 cycle after START; a second START in RUN is ignored.
REQ-040 Bench SHALL check: RESET asserted mid-RUN, then a new job -> all outputs 0 immediately, and the new job completes normally.
